// File: rtl/frost32_mem_arbiter_pkg.sv
// Shared types for the frost32 memory-port arbiter: access encodings, FSM states,
// owner tags and the latched request record.
package frost32_mem_arbiter_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  typedef enum logic [1:0] {
    Dias32  = 2'b00,
    Dias16  = 2'b01,
    Dias8   = 2'b10,
    DiasBad = 2'b11
  } DataInoutAccessSize;

  typedef enum logic [1:0] {
    StArbIdle  = 2'b00,
    StArbFetch = 2'b01,
    StArbData  = 2'b10,
    StArbResp  = 2'b11
  } MemArbState;

  typedef enum logic {
    MaoFetch = 1'b0,
    MaoData  = 1'b1
  } MemArbOwner;

  typedef struct packed {
    logic [MEM_ARB_ADDR_W-1:0] addr;
    logic [MEM_ARB_DATA_W-1:0] wdata;
    DataInoutAccessType        access_type;
    DataInoutAccessSize        access_size;
  } MemArbReq;

  // Natural alignment: words on 4-byte, halves on 2-byte boundaries.
  function automatic logic mem_arb_legal(input DataInoutAccessSize size,
                                         input logic [1:0]         addr_lo);
    logic ok;
    case (size)
      Dias32:  ok = (addr_lo == 2'b00);
      Dias16:  ok = (addr_lo[0] == 1'b0);
      Dias8:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/frost32_mem_arbiter_watchdog.sv
// Wait-cycle watchdog for the arbiter: counts consecutive busy cycles and flags
// the cycle on which the last permitted wait is being spent.
module frost32_mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == LastCnt);

endmodule

// File: rtl/frost32_mem_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and data
// load/store. Define FROST32_MEM_ARB_ROUND_ROBIN_EN for round-robin grant on ties.
module frost32_mem_arbiter
  import frost32_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_done,
  output logic                  fetch_err,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  data_req,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  data_access_type,
  input  logic [1:0]            data_access_size,
  output logic                  data_done,
  output logic                  data_err,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_access_type,
  output logic [1:0]            mem_access_size,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_wait,
  output logic                  timeout_flag
);

  MemArbState            state_q;
  MemArbReq              req_q;
  logic                  mem_req_q;
  logic                  fetch_done_q, fetch_err_q;
  logic                  data_done_q, data_err_q;
  logic [DATA_WIDTH-1:0] fetch_rdata_q, data_rdata_q;
  logic                  timeout_q;

  MemArbReq fetch_pkt, data_pkt, win_pkt_d;
  logic     any_req, grant_data_d, legal_d;
  logic     in_xfer, wd_clear, wd_count_en, wd_expire;

  assign any_req = fetch_req | data_req;

`ifdef FROST32_MEM_ARB_ROUND_ROBIN_EN
  MemArbOwner last_owner_q;

  // On a tie the requester that did not own the port last time wins.
  always_comb begin
    grant_data_d = data_req;
    if (fetch_req && data_req) begin
      grant_data_d = (last_owner_q == MaoFetch);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= MaoFetch;
    end else if (state_q == StArbIdle && any_req) begin
      last_owner_q <= grant_data_d ? MaoData : MaoFetch;
    end
  end
`else
  always_comb begin
    grant_data_d = data_req;
  end
`endif

  always_comb begin
    fetch_pkt = '{addr: fetch_addr, wdata: '0, access_type: DiatRead,
                  access_size: Dias32};
    data_pkt  = '{addr: data_addr, wdata: data_wdata,
                  access_type: DataInoutAccessType'(data_access_type),
                  access_size: DataInoutAccessSize'(data_access_size)};
    win_pkt_d = grant_data_d ? data_pkt : fetch_pkt;
    legal_d   = mem_arb_legal(win_pkt_d.access_size, win_pkt_d.addr[1:0]);
  end

  assign in_xfer     = (state_q == StArbFetch) || (state_q == StArbData);
  assign wd_count_en = in_xfer && mem_wait;
  assign wd_clear    = !in_xfer || !mem_wait || wd_expire;

  frost32_mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expire   (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StArbIdle;
      req_q         <= '0;
      mem_req_q     <= 1'b0;
      fetch_done_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_rdata_q <= '0;
      data_done_q   <= 1'b0;
      data_err_q    <= 1'b0;
      data_rdata_q  <= '0;
      timeout_q     <= 1'b0;
    end else begin
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      unique case (state_q)
        StArbIdle: begin
          if (any_req) begin
            req_q <= win_pkt_d;
            if (!legal_d) begin
              // Illegal access never reaches memory; report it right away.
              state_q <= StArbResp;
              if (grant_data_d) begin
                data_done_q  <= 1'b1;
                data_err_q   <= 1'b1;
                data_rdata_q <= '0;
              end else begin
                fetch_done_q  <= 1'b1;
                fetch_err_q   <= 1'b1;
                fetch_rdata_q <= '0;
              end
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= grant_data_d ? StArbData : StArbFetch;
            end
          end
        end
        StArbFetch, StArbData: begin
          // mem_wait still high here means the watchdog has run out.
          if (!mem_wait || wd_expire) begin
            mem_req_q <= 1'b0;
            state_q   <= StArbResp;
            if (mem_wait) begin
              timeout_q <= 1'b1;
            end
            if (state_q == StArbData) begin
              data_done_q  <= 1'b1;
              data_err_q   <= mem_wait;
              data_rdata_q <= (mem_wait || req_q.access_type == DiatWrite)
                              ? '0 : mem_rdata;
            end else begin
              fetch_done_q  <= 1'b1;
              fetch_err_q   <= mem_wait;
              fetch_rdata_q <= mem_wait ? '0 : mem_rdata;
            end
          end
        end
        StArbResp: begin
          state_q <= StArbIdle;
        end
        default: begin
          state_q <= StArbIdle;
        end
      endcase
    end
  end

  assign fetch_done      = fetch_done_q;
  assign fetch_err       = fetch_err_q;
  assign fetch_rdata     = fetch_rdata_q;
  assign data_done       = data_done_q;
  assign data_err        = data_err_q;
  assign data_rdata      = data_rdata_q;
  assign mem_req         = mem_req_q;
  assign mem_addr        = req_q.addr;
  assign mem_wdata       = req_q.wdata;
  assign mem_access_type = req_q.access_type;
  assign mem_access_size = req_q.access_size;
  assign timeout_flag    = timeout_q;

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// Directed plus randomized bench for frost32_mem_arbiter against a transaction-level model.
module tb_frost32_mem_arbiter;
  import frost32_mem_arbiter_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, fetch_done, fetch_err;
  logic [31:0] fetch_addr, fetch_rdata;
  logic        data_req, data_done, data_err, data_access_type;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [1:0]  data_access_size, mem_access_size;
  logic        mem_req, mem_access_type, mem_wait, timeout_flag;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  frost32_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .fetch_err(fetch_err), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_access_type(data_access_type), .data_access_size(data_access_size),
    .data_done(data_done), .data_err(data_err), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_access_type(mem_access_type), .mem_access_size(mem_access_size),
    .mem_rdata(mem_rdata), .mem_wait(mem_wait), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        typ;
    logic [1:0]  size;
    logic [31:0] rdata;
    int unsigned waits;
  } txn_t;

  int total = 0;
  int bad   = 0;

  logic        exp_f_err, exp_d_err, exp_tf;
  logic [31:0] exp_f_rd, exp_d_rd;
  bit          f_rd_known, d_rd_known;
  bit          last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit legal(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      Dias32:  return (addr % 4) == 0;
      Dias16:  return (addr % 2) == 0;
      Dias8:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk_held();
    chk("fetch_err_hold", fetch_err, exp_f_err);
    chk("data_err_hold", data_err, exp_d_err);
    if (f_rd_known) chk("fetch_rdata_hold", fetch_rdata, exp_f_rd);
    if (d_rd_known) chk("data_rdata_hold", data_rdata, exp_d_rd);
    chk("timeout_flag", timeout_flag, exp_tf);
  endtask

  // One granted access from the cycle its request is being sampled until the idle cycle after done.
  task automatic do_grant(input bit is_data, input txn_t t);
    bit          ok, tmo;
    int unsigned ncyc;
    logic [1:0]  sz;
    logic [31:0] exp_rd;
    sz        = is_data ? t.size : Dias32;
    last_data = is_data;
    ok        = legal(sz, t.addr);
    tmo       = ok && (t.waits >= TO);
    if (ok) begin
      ncyc = tmo ? TO : t.waits + 1;
      for (int k = 0; k < int'(ncyc); k++) begin
        tick();
        chk("mem_req_on", mem_req, 1);
        chk("mem_addr", mem_addr, t.addr);
        chk("mem_wdata", mem_wdata, is_data ? t.wdata : 32'h0);
        chk("mem_type", mem_access_type, is_data ? t.typ : DiatRead);
        chk("mem_size", mem_access_size, sz);
        chk("no_early_done", {fetch_done, data_done}, 0);
        mem_wait  = (k < int'(t.waits));
        mem_rdata = (k == int'(ncyc) - 1) ? t.rdata : $urandom;
      end
    end
    tick();
    exp_rd = (!ok || tmo || (is_data && t.typ == DiatWrite)) ? 32'h0 : t.rdata;
    if (tmo) exp_tf = 1'b1;
    if (is_data) begin
      exp_d_err = !ok || tmo;
      exp_d_rd = exp_rd;
      d_rd_known = ok;
    end else begin
      exp_f_err = !ok || tmo;
      exp_f_rd = exp_rd;
      f_rd_known = ok;
    end
    chk("done_pulse", {fetch_done, data_done}, is_data ? 2'b01 : 2'b10);
    chk("mem_req_off", mem_req, 0);
    chk_held();
    if (is_data) data_req = 1'b0;
    else fetch_req = 1'b0;
    mem_wait = $urandom;
    tick();
    chk("idle_no_done", {fetch_done, data_done}, 0);
    chk("idle_mem_req", mem_req, 0);
  endtask

  function automatic bit pick_data_on_tie();
`ifdef FROST32_MEM_ARB_ROUND_ROBIN_EN
    return !last_data;
`else
    return 1'b1;
`endif
  endfunction

  task automatic serve(input bit f_en, input txn_t f, input bit d_en, input txn_t d);
    bit first_data;
    fetch_req        = f_en;
    fetch_addr       = f.addr;
    data_req         = d_en;
    data_addr        = d.addr;
    data_wdata       = d.wdata;
    data_access_type = d.typ;
    data_access_size = d.size;
    if (f_en && d_en) begin
      first_data = pick_data_on_tie();
      do_grant(first_data, first_data ? d : f);
      do_grant(!first_data, first_data ? f : d);
    end else if (d_en) begin
      do_grant(1'b1, d);
    end else if (f_en) begin
      do_grant(1'b0, f);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic typ, input logic [1:0] size,
                              input logic [31:0] rdata, input int unsigned waits);
    txn_t t;
    t.addr = addr; t.wdata = wdata; t.typ = typ; t.size = size;
    t.rdata = rdata; t.waits = waits;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return mk(a, $urandom, 1'($urandom), 2'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 5));
  endfunction

  task automatic reset_model();
    exp_f_err = 0; exp_d_err = 0; exp_tf = 0;
    exp_f_rd = 0; exp_d_rd = 0;
    f_rd_known = 1; d_rd_known = 1;
    last_data = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL tb_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    txn_t none, t1, t2;
    bit   fe, de;
    none = mk(0, 0, DiatRead, Dias32, 0, 0);
    rst_n = 0; fetch_req = 0; fetch_addr = 0; data_req = 0; data_addr = 0;
    data_wdata = 0; data_access_type = 0; data_access_size = 0;
    mem_rdata = 0; mem_wait = 0;
    reset_model();
    @(negedge clk); @(negedge clk);
    chk("rst_outs", {fetch_done, fetch_err, data_done, data_err, mem_req,
                     mem_access_type, mem_access_size, timeout_flag}, 0);
    chk("rst_rdata", fetch_rdata | data_rdata, 0);
    chk("rst_mem_addr", mem_addr | mem_wdata, 0);
    rst_n = 1;
    tick();

    // fetch only
    serve(1, mk(32'h100, 0, DiatRead, Dias32, 32'hDEADBEEF, 0), 0, none);
    // simultaneous fetch and data read
    serve(1, mk(32'h400, 0, DiatRead, Dias32, 32'hCAFE0001, 0),
          1, mk(32'h200, 32'h55, DiatRead, Dias16, 32'h0000ABCD, 0));
    // store with three wait cycles
    serve(0, none, 1, mk(32'h302, 32'h1234, DiatWrite, Dias16, 32'hFFFFFFFF, 3));
    // misaligned word, then bad size
    serve(0, none, 1, mk(32'h1, 32'h9, DiatRead, Dias32, 32'h77, 0));
    serve(0, none, 1, mk(32'h0, 32'h9, DiatRead, DiasBad, 32'h77, 0));
    // watchdog abort then a successful access
    serve(1, mk(32'h80, 0, DiatRead, Dias32, 32'h11111111, 10), 0, none);
    serve(0, none, 1, mk(32'h84, 0, DiatRead, Dias32, 32'h22222222, 1));
    // tie again, exercising round-robin ordering when enabled
    serve(1, mk(32'h500, 0, DiatRead, Dias32, 32'h33333333, 2),
          1, mk(32'h600, 32'hA5, DiatWrite, Dias8, 32'h44444444, 0));

    for (int i = 0; i < 60; i++) begin
      t1 = rnd_txn();
      t2 = rnd_txn();
      fe = 1'($urandom);
      de = 1'($urandom);
      if (!fe && !de) fe = 1;
      serve(fe, t1, de, t2);
    end

    // reset in the middle of a stalled fetch
    fetch_req = 1; fetch_addr = 32'h40;
    tick();
    chk("pre_rst_mem_req", mem_req, 1);
    mem_wait = 1;
    tick();
    #2 rst_n = 0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_flags", {fetch_done, data_done, timeout_flag}, 0);
    fetch_req = 0;
    reset_model();
    tick();
    chk("rst_hold_no_done", {fetch_done, data_done, mem_req}, 0);
    rst_n = 1;
    tick();
    chk("post_rst_no_done", {fetch_done, data_done}, 0);
    serve(1, mk(32'h44, 0, DiatRead, Dias32, 32'h600DF00D, 1), 0, none);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
